// File: rtl/crc10_pkg.sv
// Shared CRC-10 definitions (poly 1+x+x^2+x^3+x^6+x^9+x^10) used by the generator and checker.
package crc10_pkg;

    localparam int unsigned CRC_W = 10;
    localparam logic [CRC_W-1:0] POLY = 10'h24F;

    typedef logic [CRC_W-1:0] crc_t;

    typedef enum logic {
        IDLE,
        FRAME
    } state_t;

    // One 10-bit word per call: (state ^ data) * x^10 mod P.
    function automatic crc_t crc10_next(crc_t state, crc_t data);
        crc_t x;
        x = state ^ data;
        for (int i = 0; i < CRC_W; i++) begin
            if (x[CRC_W-1]) begin
                x = {x[CRC_W-2:0], 1'b0} ^ POLY;
            end else begin
                x = {x[CRC_W-2:0], 1'b0};
            end
        end
        return x;
    endfunction

endpackage

// File: rtl/crc10_lfsr.sv
// CRC-10 LFSR register with load-init / advance / hold controls.
module crc10_lfsr
    import crc10_pkg::*;
#(
    parameter crc_t INIT = 10'h000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_init,
    input  logic             advance,
    input  logic [CRC_W-1:0] din,
    output logic [CRC_W-1:0] state,
    output logic [CRC_W-1:0] residue
);

    crc_t lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= INIT;
        end else if (load_init) begin
            lfsr_q <= crc10_next(INIT, din);
        end else if (advance) begin
            lfsr_q <= crc10_next(lfsr_q, din);
        end
    end

    assign state   = lfsr_q;
    // Feeding the received CRC word through the LFSR leaves zero when it matches.
    assign residue = crc10_next(lfsr_q, din);

endmodule

// File: rtl/crc10_checker.sv
// Receive-side CRC-10 frame checker; last beat of each frame carries the CRC.
// Optional statistics counters are enabled by defining CRC10_CHK_STAT_EN.
module crc10_checker
    import crc10_pkg::*;
#(
    parameter crc_t        INIT  = 10'h000,
    parameter int unsigned LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CRC_W-1:0] din,
    input  logic             din_vld,
    input  logic             din_sof,
    input  logic             din_eof,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [CRC_W-1:0] crc_calc,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_abort,
    output logic             busy
`ifdef CRC10_CHK_STAT_EN
    ,
    input  logic             stat_clr,
    output logic [15:0]      stat_frames,
    output logic [15:0]      stat_errs
`endif
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    crc_t             lfsr_state;
    crc_t             lfsr_residue;
    logic             load_init;
    logic             advance;

    assign load_init = din_vld & din_sof & ~din_eof;
    assign advance   = din_vld & ~din_sof & ~din_eof & (state == FRAME);

    crc10_lfsr #(
        .INIT(INIT)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_init(load_init),
        .advance  (advance),
        .din      (din),
        .state    (lfsr_state),
        .residue  (lfsr_residue)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_q       <= '0;
            done        <= 1'b0;
            crc_ok      <= 1'b0;
            crc_err     <= 1'b0;
            crc_calc    <= '0;
            frame_len   <= '0;
            frame_abort <= 1'b0;
        end else begin
            done        <= 1'b0;
            crc_ok      <= 1'b0;
            crc_err     <= 1'b0;
            frame_abort <= 1'b0;
            if (din_vld) begin
                if (din_sof) begin
                    // A new sof always restarts; an open frame is reported as aborted.
                    frame_abort <= (state == FRAME);
                    if (din_eof) begin
                        done      <= 1'b1;
                        crc_ok    <= (din == INIT);
                        crc_err   <= (din != INIT);
                        crc_calc  <= INIT;
                        frame_len <= '0;
                        state     <= IDLE;
                    end else begin
                        len_q <= LEN_ONE;
                        state <= FRAME;
                    end
                end else if (state == FRAME) begin
                    if (din_eof) begin
                        done      <= 1'b1;
                        crc_ok    <= (lfsr_residue == '0);
                        crc_err   <= (lfsr_residue != '0);
                        crc_calc  <= lfsr_state;
                        frame_len <= len_q;
                        state     <= IDLE;
                    end else if (len_q != '1) begin
                        len_q <= len_q + LEN_ONE;
                    end
                end
            end
        end
    end

    assign busy = (state == FRAME);

`ifdef CRC10_CHK_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames <= '0;
            stat_errs   <= '0;
        end else if (stat_clr) begin
            stat_frames <= '0;
            stat_errs   <= '0;
        end else begin
            if (done && stat_frames != 16'hFFFF) begin
                stat_frames <= stat_frames + 16'd1;
            end
            if (crc_err && stat_errs != 16'hFFFF) begin
                stat_errs <= stat_errs + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_crc10_checker.sv
// Randomized self-checking bench for crc10_checker against a serial-division reference model.
module tb_crc10_checker;

    localparam logic [9:0] INIT_V = 10'h000;
    localparam logic [9:0] POLY_V = 10'h24F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  din = '0;
    logic        din_vld = 1'b0;
    logic        din_sof = 1'b0;
    logic        din_eof = 1'b0;
    logic        done;
    logic        crc_ok;
    logic        crc_err;
    logic [9:0]  crc_calc;
    logic [11:0] frame_len;
    logic        frame_abort;
    logic        busy;
`ifdef CRC10_CHK_STAT_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_frames;
    logic [15:0] stat_errs;
`endif

    always #5 clk = ~clk;

    crc10_checker #(
        .INIT (INIT_V),
        .LEN_W(12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_vld    (din_vld),
        .din_sof    (din_sof),
        .din_eof    (din_eof),
        .done       (done),
        .crc_ok     (crc_ok),
        .crc_err    (crc_err),
        .crc_calc   (crc_calc),
        .frame_len  (frame_len),
        .frame_abort(frame_abort),
        .busy       (busy)
`ifdef CRC10_CHK_STAT_EN
        ,
        .stat_clr   (stat_clr),
        .stat_frames(stat_frames),
        .stat_errs  (stat_errs)
`endif
    );

    typedef struct packed {
        logic        ok;
        logic [9:0]  calc;
        logic [11:0] len;
    } exp_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         abort_exp = 0;
    int         abort_seen = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [9:0] m_pay[$];
    bit         m_open = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    // Bit-serial long division of the concatenated payload, first word's MSB first.
    function automatic logic [9:0] ref_crc(input logic [9:0] words[$]);
        logic [9:0] r;
        logic       fb;
        r = INIT_V;
        foreach (words[i]) begin
            for (int b = 9; b >= 0; b--) begin
                fb = r[9] ^ words[i][b];
                r  = {r[8:0], 1'b0} ^ (fb ? POLY_V : 10'h000);
            end
        end
        return r;
    endfunction

    task automatic model_beat(input logic [9:0] d, input logic sof, input logic eof);
        exp_t e;
        int   n;
        if (sof) begin
            if (m_open) abort_exp++;
            if (eof) begin
                e.ok   = (d == INIT_V);
                e.calc = INIT_V;
                e.len  = '0;
                exp_q.push_back(e);
                m_open = 1'b0;
            end else begin
                m_pay.delete();
                m_pay.push_back(d);
                m_open = 1'b1;
            end
        end else if (m_open) begin
            if (eof) begin
                n      = m_pay.size();
                e.calc = ref_crc(m_pay);
                e.ok   = (d == e.calc);
                e.len  = (n > 4095) ? 12'hFFF : 12'(n);
                exp_q.push_back(e);
                m_open = 1'b0;
            end else begin
                m_pay.push_back(d);
            end
        end
    endtask

    task automatic send(input logic [9:0] d, input logic sof, input logic eof);
        @(negedge clk);
        din     = d;
        din_vld = 1'b1;
        din_sof = sof;
        din_eof = eof;
        model_beat(d, sof, eof);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_vld = 1'b0;
            din     = 10'($urandom);
            din_sof = 1'($urandom);
            din_eof = 1'($urandom);
        end
    endtask

    task automatic send_frame(input int n, input bit flip, input bit gaps);
        logic [9:0] pay[$];
        logic [9:0] crc;
        logic [9:0] w;
        int         fbeat;
        int         fbit;
        for (int i = 0; i < n; i++) pay.push_back(10'($urandom_range(0, 1023)));
        crc   = ref_crc(pay);
        fbeat = $urandom_range(0, n);
        fbit  = $urandom_range(0, 9);
        for (int i = 0; i <= n; i++) begin
            w = (i < n) ? pay[i] : crc;
            if (flip && i == fbeat) w[fbit] = ~w[fbit];
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(w, i == 0, i == n);
        end
    endtask

    // Every done is matched against the model; flags must be quiet otherwise.
    always @(negedge clk) begin
        if (frame_abort) abort_seen++;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("crc_ok", 32'(crc_ok), 32'(mon_e.ok));
                check("crc_err", 32'(crc_err), 32'(!mon_e.ok));
                check("crc_calc", 32'(crc_calc), 32'(mon_e.calc));
                check("frame_len", 32'(frame_len), 32'(mon_e.len));
            end
        end else begin
            check("flags_without_done", 32'({crc_ok, crc_err}), 32'd0);
        end
    end

    initial begin
        idle(3);
        check("rst_done", 32'(done), 32'd0);
        check("rst_calc", 32'(crc_calc), 32'd0);
        check("rst_len", 32'(frame_len), 32'd0);
        check("rst_abort", 32'(frame_abort), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single-word frame: empty payload CRC is INIT.
        send(10'h000, 1'b1, 1'b1);
        idle(1);
        check("single_word", 32'({done, crc_ok, crc_err}), 32'b110);
        check("single_len", 32'(frame_len), 32'd0);

        send(10'h001, 1'b1, 1'b0);
        idle(1);
        check("busy_in_frame", 32'(busy), 32'd1);
        send(10'h24F, 1'b0, 1'b1);
        idle(1);
        check("two_word_ok", 32'({done, crc_ok, crc_err}), 32'b110);
        check("busy_after_eof", 32'(busy), 32'd0);
        idle(3);
        check("calc_hold", 32'(crc_calc), 32'h24F);
        check("len_hold", 32'(frame_len), 32'd1);

        send(10'h001, 1'b1, 1'b0);
        send(10'h24E, 1'b0, 1'b1);
        idle(1);
        check("two_word_err", 32'({done, crc_ok, crc_err}), 32'b101);
        check("err_calc", 32'(crc_calc), 32'h24F);

        // Abort by sof+eof mid-frame, then an orphan eof.
        send(10'h001, 1'b1, 1'b0);
        send(10'h000, 1'b1, 1'b1);
        idle(1);
        check("abort_with_done", 32'({frame_abort, done, crc_ok}), 32'b111);
        check("abort_len", 32'(frame_len), 32'd0);
        send(10'h123, 1'b0, 1'b1);
        idle(1);
        check("orphan_eof", 32'(done), 32'd0);
        idle(2);

        // Random 64-word frames, good then single-bit corrupted, with and without gaps.
        for (int i = 0; i < 12; i++) send_frame(64, i >= 6, (i % 3) != 0);
        idle(3);

        // Reset in the middle of a frame.
        send(10'h005, 1'b1, 1'b0);
        send(10'h007, 1'b0, 1'b0);
        @(negedge clk);
        din_vld = 1'b0;
        rst_n   = 1'b0;
        m_open  = 1'b0;
        m_pay.delete();
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_calc", 32'(crc_calc), 32'd0);
        check("midrst_len", 32'(frame_len), 32'd0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(5, 1'b0, 1'b0);
        idle(1);
        check("post_rst_ok", 32'({done, crc_ok}), 32'b11);

        // Payload longer than the counter range saturates the length.
        send_frame(4100, 1'b0, 1'b0);
        idle(2);
        check("len_sat", 32'(frame_len), 32'hFFF);

`ifdef CRC10_CHK_STAT_EN
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        for (int i = 0; i < 5; i++) send_frame(8, i >= 3, 1'b0);
        idle(3);
        check("stat_frames", 32'(stat_frames), 32'd5);
        check("stat_errs", 32'(stat_errs), 32'd2);
        send_frame(4, 1'b1, 1'b0);
        @(negedge clk);
        din_vld  = 1'b0;
        stat_clr = done;
        @(negedge clk);
        stat_clr = 1'b0;
        check("stat_clr_frames", 32'(stat_frames), 32'd0);
        check("stat_clr_errs", 32'(stat_errs), 32'd0);
`endif

        idle(4);
        check("results_pending", 32'(exp_q.size()), 32'd0);
        check("abort_count", 32'(abort_seen), 32'(abort_exp));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
